aes_avalon_master: RTL and testbench
====================================

AES_AVALON_MASTER -- requirements
Module: aes_avalon_master

Interface
REQ-001 Parameter POLL_LIMIT, default 1023: maximum status polls per wait phase before abort.
REQ-002 iClk  in  1  single clock; all logic is rising-edge.
REQ-003 iReset_n  in  1  asynchronous active-low reset.
REQ-004 iStart  in  1  request one AES block operation; accepted only in IDLE.
REQ-005 iEncdec  in  1  1 = encrypt, 0 = decrypt.
REQ-006 iKeylen  in  1  1 = 256-bit key, 0 = 128-bit key.
REQ-007 iKey  in  256  key; 128-bit keys occupy [255:128].
REQ-008 iBlock  in  128  input block.
REQ-009 oBusy  out  1  high from the iStart acceptance cycle until the oDone cycle.
REQ-010 oDone  out  1  one-cycle pulse at operation end.
REQ-011 oError  out  1  valid with oDone; 1 = poll timeout.
REQ-012 oResult  out  128  result block, held until the next oDone.
REQ-013 oChipselect, oWrite, oRead  out  1 each  Avalon-MM master controls toward the AES slave.
REQ-014 oAddress  out  8  word address; oWrite_data  out  32; iRead_data  in  32.

Function
REQ-015 Register map: CTRL 0x08 (bit0 init, bit1 next), STATUS 0x09 (bit0 ready, bit1 valid), CONFIG 0x0A (bit0 encdec, bit1 keylen), KEY 0x10-0x17, BLOCK 0x20-0x23, RESULT 0x30-0x33.
REQ-016 Word order is MSB first: 0x10 <- iKey[255:224], 0x20 <- iBlock[127:96], 0x30 -> oResult[127:96].
REQ-017 Write: one cycle with oChipselect=1, oWrite=1, oRead=0, address and data valid; the slave has no waitrequest.
REQ-018 Read: issue cycle with oChipselect=1, oRead=1, then a sample cycle with oRead=0 and oAddress held; iRead_data is captured at the end of the sample cycle.
REQ-019 oWrite and oRead are never both 1; oChipselect=0 when no access is in progress.
REQ-020 iKey/iBlock/iEncdec/iKeylen are captured on iStart acceptance; later changes are ignored.
REQ-021 FSM: IDLE -> WR_KEY (8 writes, all 8 words regardless of keylen) -> WR_CFG -> WR_INIT (CTRL=0x1) -> GAP1 -> POLL_READY -> WR_BLOCK (4) -> WR_NEXT (CTRL=0x2) -> GAP2 -> POLL_VALID -> RD_RESULT (4 reads) -> DONE -> IDLE.
REQ-022 GAP states are one idle bus cycle, so the first poll cannot observe stale status.
REQ-023 POLL_* repeats 2-cycle reads until the target status bit is 1; polls are counted per phase.
REQ-024 If the poll count reaches POLL_LIMIT without success: go to DONE with oError=1 and oResult unchanged.
REQ-025 Minimum latency (both polls succeed first time): oDone is asserted 29 cycles after the acceptance cycle.
REQ-026 iStart while oBusy=1 is ignored; iStart in the DONE cycle is ignored.

Reset
REQ-027 Asynchronous reset, at any time including mid-sequence, forces IDLE and sets all outputs to 0, including oResult and oAddress.
REQ-028 After reset release, the first accepted iStart always performs the full key sequence.

Configuration
REQ-029 With AES_MASTER_KEY_CACHE_EN defined: the last successfully loaded key and keylen are stored; if both match on acceptance, the FSM skips WR_KEY, WR_INIT, GAP1 and POLL_READY (WR_CFG is still performed), giving a minimum latency of 17 cycles.
REQ-030 The cache is invalidated by reset or by a timeout in any operation.
REQ-031 Without AES_MASTER_KEY_CACHE_EN: no cache storage exists and every operation takes the full path.

Structure
REQ-032 The shared package aes_master_pkg holds the register addresses, CTRL/STATUS bit indices and the FSM state enum.
REQ-033 Single module; no sub-module is required.

Verification
REQ-034 FIPS-197 AES-128 encrypt, key 000102..0f, block 00112233..ff, slave model always ready -> oResult 69c4e0d86a7b0430d8cdb78070b4c55a, oDone at cycle 29, oError=0.
REQ-035 Slave holds valid=0 for 5 polls -> oDone is delayed 10 cycles; the bus trace shows 6 reads of address 0x09 in the POLL_VALID phase.
REQ-036 POLL_LIMIT=4, ready never asserted -> oDone with oError=1 after 4 polls; oResult is unchanged.
REQ-037 Assert iReset_n=0 during WR_BLOCK -> all outputs 0 immediately; the next iStart writes 0x10 first.
REQ-038 With AES_MASTER_KEY_CACHE_EN, two operations with the same key -> the second has no writes to 0x10-0x17 and oDone at cycle 17; with a changed key, full path at 29.
REQ-039 iStart pulsed during busy -> ignored; exactly one oDone per accepted start.

Source files
------------

// File: rtl/aes_master_pkg.sv
// Shared definitions for the AES Avalon-MM master: slave register map,
// control/status bit positions and the sequencer state encoding.
package aes_master_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_CONFIG = 8'h0A;
  localparam logic [7:0] ADDR_KEY    = 8'h10;
  localparam logic [7:0] ADDR_BLOCK  = 8'h20;
  localparam logic [7:0] ADDR_RESULT = 8'h30;

  localparam int CTRL_INIT_BIT    = 0;
  localparam int CTRL_NEXT_BIT    = 1;
  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_VALID_BIT = 1;
  localparam int CFG_ENCDEC_BIT   = 0;
  localparam int CFG_KEYLEN_BIT   = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_KEY,
    S_WR_CFG,
    S_WR_INIT,
    S_GAP1,
    S_POLL_READY,
    S_WR_BLOCK,
    S_WR_NEXT,
    S_GAP2,
    S_POLL_VALID,
    S_RD_RESULT,
    S_DONE
  } state_e;

endpackage

// File: rtl/aes_avalon_master.sv
// Avalon-MM master that sequences one AES block operation on a memory-mapped AES core.
// Optional key cache enabled by defining AES_MASTER_KEY_CACHE_EN.
//
// state        | meaning
// S_IDLE       | waiting for iStart
// S_WR_KEY     | writing 8 key words, MSB word first
// S_WR_CFG     | writing encdec/keylen
// S_WR_INIT    | CTRL.init pulse
// S_GAP1       | idle bus cycle before ready polling
// S_POLL_READY | 2-cycle status reads until ready
// S_WR_BLOCK   | writing 4 block words
// S_WR_NEXT    | CTRL.next pulse
// S_GAP2       | idle bus cycle before valid polling
// S_POLL_VALID | 2-cycle status reads until valid
// S_RD_RESULT  | 4 two-cycle result reads
// S_DONE       | oDone pulse, oError qualified
module aes_avalon_master
  import aes_master_pkg::*;
#(
  parameter int POLL_LIMIT = 1023
) (
  input  logic         iClk,
  input  logic         iReset_n,
  input  logic         iStart,
  input  logic         iEncdec,
  input  logic         iKeylen,
  input  logic [255:0] iKey,
  input  logic [127:0] iBlock,
  output logic         oBusy,
  output logic         oDone,
  output logic         oError,
  output logic [127:0] oResult,
  output logic         oChipselect,
  output logic         oWrite,
  output logic         oRead,
  output logic [7:0]   oAddress,
  output logic [31:0]  oWrite_data,
  input  logic [31:0]  iRead_data
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic           rd_ph_q, rd_ph_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [255:0]   key_q, key_d;
  logic [127:0]   blk_q, blk_d;
  logic           encdec_q, encdec_d;
  logic           keylen_q, keylen_d;
  logic [95:0]    rbuf_q, rbuf_d;
  logic [127:0]   result_q, result_d;
  logic           err_q, err_d;
  logic           skip_q, skip_d;

  logic           hit;
  logic           ready_ok;
  logic           timeout;
  logic           poll_bit;
  logic           cs, wr, rd, done;
  logic [7:0]     addr;
  logic [31:0]    wdata;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rd_ph_q  <= 1'b0;
      poll_q   <= '0;
      key_q    <= '0;
      blk_q    <= '0;
      encdec_q <= 1'b0;
      keylen_q <= 1'b0;
      rbuf_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_ph_q  <= rd_ph_d;
      poll_q   <= poll_d;
      key_q    <= key_d;
      blk_q    <= blk_d;
      encdec_q <= encdec_d;
      keylen_q <= keylen_d;
      rbuf_q   <= rbuf_d;
      result_q <= result_d;
      err_q    <= err_d;
      skip_q   <= skip_d;
    end
  end

  // Key and block are rotated one word per write so the outgoing word is always the top slice.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_ph_d  = rd_ph_q;
    poll_d   = poll_q;
    key_d    = key_q;
    blk_d    = blk_q;
    encdec_d = encdec_q;
    keylen_d = keylen_q;
    rbuf_d   = rbuf_q;
    result_d = result_q;
    err_d    = err_q;
    skip_d   = skip_q;
    ready_ok = 1'b0;
    timeout  = 1'b0;
    poll_bit = 1'b0;
    cs       = 1'b0;
    wr       = 1'b0;
    rd       = 1'b0;
    done     = 1'b0;
    addr     = '0;
    wdata    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          key_d    = iKey;
          blk_d    = iBlock;
          encdec_d = iEncdec;
          keylen_d = iKeylen;
          err_d    = 1'b0;
          idx_d    = '0;
          skip_d   = hit;
          state_d  = hit ? S_WR_CFG : S_WR_KEY;
        end
      end
      S_WR_KEY: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_KEY + {5'd0, idx_q};
        wdata = key_q[255:224];
        key_d = {key_q[223:0], key_q[255:224]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_WR_CFG;
      end
      S_WR_CFG: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_CONFIG;
        wdata[CFG_ENCDEC_BIT] = encdec_q;
        wdata[CFG_KEYLEN_BIT] = keylen_q;
        state_d = skip_q ? S_WR_BLOCK : S_WR_INIT;
      end
      S_WR_INIT: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_CTRL;
        wdata[CTRL_INIT_BIT] = 1'b1;
        state_d = S_GAP1;
      end
      S_GAP1: begin
        poll_d  = '0;
        rd_ph_d = 1'b0;
        state_d = S_POLL_READY;
      end
      S_POLL_READY, S_POLL_VALID: begin
        cs      = 1'b1;
        rd      = !rd_ph_q;
        addr    = ADDR_STATUS;
        rd_ph_d = !rd_ph_q;
        poll_bit = (state_q == S_POLL_READY) ? iRead_data[STATUS_READY_BIT]
                                             : iRead_data[STATUS_VALID_BIT];
        if (rd_ph_q) begin
          if (poll_bit) begin
            ready_ok = (state_q == S_POLL_READY);
            state_d  = (state_q == S_POLL_READY) ? S_WR_BLOCK : S_RD_RESULT;
          end else if (poll_q == PCW'(POLL_LIMIT - 1)) begin
            timeout = 1'b1;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
      S_WR_BLOCK: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_BLOCK + {5'd0, idx_q};
        wdata = blk_q[127:96];
        blk_d = {blk_q[95:0], blk_q[127:96]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd3) begin
          idx_d   = '0;
          state_d = S_WR_NEXT;
        end
      end
      S_WR_NEXT: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_CTRL;
        wdata[CTRL_NEXT_BIT] = 1'b1;
        state_d = S_GAP2;
      end
      S_GAP2: begin
        poll_d  = '0;
        rd_ph_d = 1'b0;
        state_d = S_POLL_VALID;
      end
      S_RD_RESULT: begin
        cs      = 1'b1;
        rd      = !rd_ph_q;
        addr    = ADDR_RESULT + {5'd0, idx_q};
        rd_ph_d = !rd_ph_q;
        if (rd_ph_q) begin
          idx_d = idx_q + 3'd1;
          // Commit only on the last word so oResult stays stable until oDone.
          if (idx_q == 3'd3) begin
            result_d = {rbuf_q, iRead_data};
            state_d  = S_DONE;
          end else begin
            rbuf_d = {rbuf_q[63:0], iRead_data};
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AES_MASTER_KEY_CACHE_EN
  logic         cache_vld_q, cache_vld_d;
  logic         cache_keylen_q, cache_keylen_d;
  logic [255:0] cache_key_q, cache_key_d;

  assign hit = cache_vld_q && (cache_key_q == iKey) && (cache_keylen_q == iKeylen);

  always_comb begin
    cache_vld_d    = cache_vld_q;
    cache_key_d    = cache_key_q;
    cache_keylen_d = cache_keylen_q;
    if (timeout) begin
      cache_vld_d = 1'b0;
    end else if (ready_ok) begin
      cache_vld_d    = 1'b1;
      cache_key_d    = key_q;
      cache_keylen_d = keylen_q;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      cache_vld_q    <= 1'b0;
      cache_key_q    <= '0;
      cache_keylen_q <= 1'b0;
    end else begin
      cache_vld_q    <= cache_vld_d;
      cache_key_q    <= cache_key_d;
      cache_keylen_q <= cache_keylen_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign oBusy       = (state_q != S_IDLE);
  assign oDone       = done;
  assign oError      = done & err_q;
  assign oResult     = result_q;
  assign oChipselect = cs;
  assign oWrite      = wr;
  assign oRead       = rd;
  assign oAddress    = addr;
  assign oWrite_data = wdata;

endmodule

// File: tb/tb_aes_avalon_master.sv
// Self-checking bench for aes_avalon_master with a behavioural AES slave and a result scoreboard.
// Latency expectations follow AES_MASTER_KEY_CACHE_EN when the bench is built with it.
module tb_aes_avalon_master;
  import aes_master_pkg::*;

  localparam int LIM   = 6;
  localparam int NEVER = 1000;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         iClk = 1'b0;
  logic         iReset_n = 1'b0;
  logic         iStart = 1'b0;
  logic         iEncdec = 1'b0;
  logic         iKeylen = 1'b0;
  logic [255:0] iKey = '0;
  logic [127:0] iBlock = '0;
  logic         oBusy, oDone, oError, oChipselect, oWrite, oRead;
  logic [127:0] oResult;
  logic [7:0]   oAddress;
  logic [31:0]  oWrite_data;
  logic [31:0]  iRead_data = '0;

  always #5 iClk = ~iClk;

  aes_avalon_master #(.POLL_LIMIT(LIM)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iStart(iStart), .iEncdec(iEncdec),
    .iKeylen(iKeylen), .iKey(iKey), .iBlock(iBlock), .oBusy(oBusy), .oDone(oDone),
    .oError(oError), .oResult(oResult), .oChipselect(oChipselect), .oWrite(oWrite),
    .oRead(oRead), .oAddress(oAddress), .oWrite_data(oWrite_data), .iRead_data(iRead_data)
  );

  typedef struct {
    logic [127:0] res;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int ready_fail = 0;
  int valid_fail = 0;
  logic [127:0] last_res = '0;
  bit mc_vld = 0;
  logic [255:0] mc_key = '0;
  logic mc_l = 0;

  function automatic logic [127:0] slave_aes(input logic [255:0] k, input logic [127:0] b,
                                             input logic e, input logic l);
    if (k[255:128] == FIPS_KEY && b == FIPS_PT && e && !l) return FIPS_CT;
    return b ^ k[255:128] ^ (l ? k[127:0] : 128'h0) ^ (e ? 128'h0 : {128{1'b1}});
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Behavioural slave: registers assembled from bus writes, status driven by poll counters
  logic [31:0]  skey [8];
  logic [31:0]  sblk [4];
  logic [1:0]   scfg = '0;
  logic [127:0] sres = '0;
  int           spoll = 0;

  always @(posedge iClk) begin
    if (oChipselect && oWrite) begin
      if (oAddress[7:3] == 5'b00010) skey[oAddress[2:0]] <= oWrite_data;
      else if (oAddress[7:2] == 6'b001000) sblk[oAddress[1:0]] <= oWrite_data;
      else if (oAddress == ADDR_CONFIG) scfg <= oWrite_data[1:0];
      else if (oAddress == ADDR_CTRL) begin
        spoll <= 0;
        if (oWrite_data[CTRL_NEXT_BIT])
          sres <= slave_aes({skey[0], skey[1], skey[2], skey[3], skey[4], skey[5], skey[6], skey[7]},
                            {sblk[0], sblk[1], sblk[2], sblk[3]}, scfg[0], scfg[1]);
      end
    end
    if (oChipselect && oRead) begin
      if (oAddress == ADDR_STATUS) begin
        iRead_data <= {30'd0, spoll >= valid_fail, spoll >= ready_fail};
        spoll <= spoll + 1;
      end else if (oAddress[7:2] == 6'b001100) begin
        case (oAddress[1:0])
          2'd0: iRead_data <= sres[127:96];
          2'd1: iRead_data <= sres[95:64];
          2'd2: iRead_data <= sres[63:32];
          default: iRead_data <= sres[31:0];
        endcase
      end else begin
        iRead_data <= '0;
      end
    end
  end

  // Bus monitor
  int prot_err = 0;
  int key_wr = 0;
  int stat_rd = 0;
  int done_cnt = 0;
  bit first_seen = 0;
  logic [7:0] first_wr = '0;

  always @(negedge iClk) begin
    if (oWrite && oRead) prot_err <= prot_err + 1;
    if (!oChipselect && (oWrite || oRead)) prot_err <= prot_err + 1;
    if (oChipselect && oWrite && oAddress[7:3] == 5'b00010) key_wr <= key_wr + 1;
    if (oChipselect && oWrite && oAddress == ADDR_CTRL) stat_rd <= 0;
    else if (oChipselect && oRead && oAddress == ADDR_STATUS) stat_rd <= stat_rd + 1;
    if (!oBusy) first_seen <= 0;
    else if (oChipselect && oWrite && !first_seen) begin
      first_wr   <= oAddress;
      first_seen <= 1;
    end
    if (oDone) done_cnt <= done_cnt + 1;
  end

  task automatic run_op(input logic [255:0] k, input logic [127:0] b, input logic e,
                        input logic l, input bit disturb, input bit fips);
    exp_t x;
    exp_t got;
    bit hit;
    bit seen;
    int t;
    int cyc;
    int kw0;
    int d0;
    hit = 0;
`ifdef AES_MASTER_KEY_CACHE_EN
    hit = mc_vld && (mc_key == k) && (mc_l == l);
`endif
    x.err = 0;
    if (hit) t = 7;
    else begin
      t = 11;
      if (ready_fail >= LIM) begin t += 2 * LIM; x.err = 1; end
      else t += 2 * ready_fail + 8;
    end
    if (!x.err) begin
      if (valid_fail >= LIM) begin t += 2 * LIM; x.err = 1; end
      else t += 2 * valid_fail + 10;
    end
    x.lat = t;
    if (!hit && ready_fail < LIM) begin mc_vld = 1; mc_key = k; mc_l = l; end
    if (x.err) mc_vld = 0;
    x.res = x.err ? last_res : (fips ? FIPS_CT : slave_aes(k, b, e, l));
    if (!x.err) last_res = x.res;
    sb.push_back(x);
    kw0 = key_wr;
    d0  = done_cnt;

    @(negedge iClk);
    iStart = 1; iKey = k; iBlock = b; iEncdec = e; iKeylen = l;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 0; iKey = rnd256(); iBlock = rnd256()[127:0]; iEncdec = ~e; iKeylen = ~l;
    n_cmp++;
    if (oBusy !== 1'b1) begin n_bad++; $display("FAIL busy_after_accept: got %b want 1", oBusy); end

    cyc = 0;
    seen = 0;
    while (!seen && cyc <= 200) begin
      if (disturb) iStart = (cyc == 3 || cyc == 10);
      if (oDone === 1'b1) seen = 1;
      else begin @(negedge iClk); cyc++; end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no oDone within %0d cycles", cyc);
      if (sb.size() > 0) void'(sb.pop_front());
      iStart = 0;
      return;
    end
    got = sb.pop_front();
    n_cmp++;
    if (oError !== got.err) begin n_bad++; $display("FAIL error_flag: got %b want %b", oError, got.err); end
    n_cmp++;
    if (oResult !== got.res) begin n_bad++; $display("FAIL result: got %h want %h", oResult, got.res); end
    n_cmp++;
    if (cyc != got.lat) begin n_bad++; $display("FAIL latency: got %0d want %0d", cyc, got.lat); end
    iStart = disturb;
    @(negedge iClk);
    iStart = 0;
    if (disturb) repeat (40) @(negedge iClk);
    n_cmp++;
    if (key_wr - kw0 != (hit ? 0 : 8)) begin
      n_bad++; $display("FAIL key_writes: got %0d want %0d", key_wr - kw0, hit ? 0 : 8);
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL done_count: got %0d want 1", done_cnt - d0); end
    n_cmp++;
    if (oBusy !== 1'b0) begin n_bad++; $display("FAIL idle_after_done: busy %b want 0", oBusy); end
  endtask

  task automatic test_reset();
    iReset_n = 0;
    repeat (2) @(negedge iClk);
    n_cmp++;
    if ({oBusy, oDone, oError, oChipselect, oWrite, oRead, oAddress, oWrite_data, oResult} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: addr %h wdata %h result %h busy %b", oAddress, oWrite_data, oResult, oBusy);
    end
    iReset_n = 1;
    @(negedge iClk);
  endtask

  task automatic test_fips();
    run_op({FIPS_KEY, 128'h0}, FIPS_PT, 1'b1, 1'b0, 0, 1);
    n_cmp++;
    if (stat_rd != 1) begin n_bad++; $display("FAIL fips_valid_polls: got %0d want 1", stat_rd); end
  endtask

  task automatic test_poll_delay();
    valid_fail = 5;
    run_op(rnd256(), rnd256()[127:0], 1'b1, 1'b1, 0, 0);
    n_cmp++;
    if (stat_rd != 6) begin n_bad++; $display("FAIL valid_poll_reads: got %0d want 6", stat_rd); end
    valid_fail = 0;
  endtask

  task automatic test_modes();
    for (int i = 0; i < 4; i++)
      run_op(rnd256(), rnd256()[127:0], i[0], i[1], 0, 0);
  endtask

  task automatic test_cache();
    logic [255:0] k;
    k = rnd256();
    run_op(k, rnd256()[127:0], 1'b1, 1'b0, 0, 0);
    run_op(k, rnd256()[127:0], 1'b0, 1'b0, 0, 0);
    run_op(k, rnd256()[127:0], 1'b1, 1'b1, 0, 0);
    k[7:0] = ~k[7:0];
    run_op(k, rnd256()[127:0], 1'b1, 1'b1, 0, 0);
  endtask

  task automatic test_timeout();
    logic [255:0] k;
    ready_fail = NEVER;
    run_op(rnd256(), rnd256()[127:0], 1'b1, 1'b0, 0, 0);
    n_cmp++;
    if (stat_rd != LIM) begin n_bad++; $display("FAIL ready_poll_reads: got %0d want %0d", stat_rd, LIM); end
    ready_fail = 0;
    k = rnd256();
    run_op(k, rnd256()[127:0], 1'b1, 1'b0, 0, 0);
    valid_fail = NEVER;
    run_op(k, rnd256()[127:0], 1'b1, 1'b0, 0, 0);
    valid_fail = 0;
    run_op(k, rnd256()[127:0], 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_busy_start();
    run_op(rnd256(), rnd256()[127:0], 1'b1, 1'b0, 1, 0);
  endtask

  task automatic test_reset_mid();
    bit hit_blk;
    int n;
    @(negedge iClk);
    iStart = 1; iKey = rnd256(); iBlock = rnd256()[127:0]; iEncdec = 1; iKeylen = 0;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 0;
    hit_blk = 0;
    n = 0;
    while (!hit_blk && n < 60) begin
      if (oWrite === 1'b1 && oAddress == ADDR_BLOCK + 8'd1) hit_blk = 1;
      else begin @(negedge iClk); n++; end
    end
    n_cmp++;
    if (!hit_blk) begin n_bad++; $display("FAIL reach_wr_block: not seen in %0d cycles", n); end
    #1 iReset_n = 0;
    #1;
    n_cmp++;
    if ({oBusy, oDone, oError, oChipselect, oWrite, oRead, oAddress, oWrite_data, oResult} !== '0) begin
      n_bad++; $display("FAIL midop_reset_outputs: addr %h wdata %h result %h busy %b", oAddress, oWrite_data, oResult, oBusy);
    end
    sb.delete();
    last_res = '0;
    mc_vld = 0;
    @(negedge iClk);
    iReset_n = 1;
    @(negedge iClk);
    run_op(rnd256(), rnd256()[127:0], 1'b0, 1'b1, 0, 0);
    n_cmp++;
    if (first_wr !== ADDR_KEY) begin n_bad++; $display("FAIL first_write_addr: got %h want %h", first_wr, ADDR_KEY); end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (prot_err != 0) begin n_bad++; $display("FAIL bus_protocol: got %0d violations want 0", prot_err); end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_poll_delay();
    test_modes();
    test_cache();
    test_timeout();
    test_busy_start();
    test_reset_mid();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
